// File: rtl/pd_math.sv
// Per-axis P/D term generator: saturated attitude error feeds a 5/8 P term
// and a gained D term taken against an error sample D_QUEUE_DEPTH updates old.
// Two-stage pipeline, 2 cycles vld -> out_vld, no back-pressure (a sample every cycle is fine).
module pd_math #(
  parameter int         D_QUEUE_DEPTH = 12,
  parameter logic [4:0] D_COEFF       = 5'd7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic signed [15:0] actual,
  input  logic signed [15:0] desired,
  output logic signed [9:0]  pterm,
  output logic signed [12:0] dterm,
  output logic               out_vld
);

  logic signed [16:0] diff_d;
  logic signed [9:0]  err_d;
  logic signed [9:0]  err_q;
  logic               s1_vld_q;

  logic signed [9:0]  queue_q [D_QUEUE_DEPTH];
  logic signed [9:0]  pterm_d, pterm_q;
  logic signed [10:0] d_diff;
  logic signed [6:0]  d_sat;
  logic signed [12:0] dterm_d, dterm_q;
  logic               out_vld_q;

  // Widen to 17 bits before subtracting so extreme angle pairs never wrap.
  assign diff_d = {actual[15], actual} - {desired[15], desired};

  // Clamp the raw error into the 10-bit working range.
  always_comb begin
    err_d = diff_d[9:0];
    if (diff_d > 17'sd511) begin
      err_d = 10'sd511;
    end else if (diff_d < -17'sd512) begin
      err_d = -10'sd512;
    end
  end

  // Stage 1: capture the saturated error and flag it for stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q    <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= vld;
      if (vld) begin
        err_q <= err_d;
      end
    end
  end

  // P term: >>>1 plus >>>3 approximates 5/8 and stays within 10 bits.
  assign pterm_d = (err_q >>> 1) + (err_q >>> 3);

  // D term differences against the oldest history entry, before this update shifts it out.
  assign d_diff = {err_q[9], err_q} - {queue_q[D_QUEUE_DEPTH-1][9], queue_q[D_QUEUE_DEPTH-1]};

  // Clamp the difference to 7 bits so the gained product fits in 13 bits.
  always_comb begin
    d_sat = d_diff[6:0];
    if (d_diff > 11'sd63) begin
      d_sat = 7'sd63;
    end else if (d_diff < -11'sd64) begin
      d_sat = -7'sd64;
    end
  end

  // Signed difference times zero-extended unsigned gain; the low 13 bits are exact.
  assign dterm_d = {{6{d_sat[6]}}, d_sat} * {8'd0, D_COEFF};

  // Stage 2: register P/D terms and the output strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pterm_q   <= '0;
      dterm_q   <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        pterm_q <= pterm_d;
        dterm_q <= dterm_d;
      end
    end
  end

  // Error history: shifts once per stage-2 update; zeros after reset act as the start-up reference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D_QUEUE_DEPTH; i++) begin
        queue_q[i] <= '0;
      end
    end else if (s1_vld_q) begin
      queue_q[0] <= err_q;
      for (int i = 1; i < D_QUEUE_DEPTH; i++) begin
        queue_q[i] <= queue_q[i-1];
      end
    end
  end

  assign pterm   = pterm_q;
  assign dterm   = dterm_q;
  assign out_vld = out_vld_q;

endmodule
